seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexes NUM_DIGITS packed BCD digits onto one shared BCD-to-seven-segment

---
 rtl/seven_seg_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed BCD seven-segment scan controller: one shared decoder, one enable per digit,
// blanking between digits and frame-aligned swapping of newly loaded display words.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank_leading,
  output logic                    W,
  output logic                    X,
  output logic                    Y,
  output logic                    Z,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    bcd_err
);

  localparam int unsigned DATA_W  = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic [DATA_W-1:0]   pending_q, pending_d;
  logic                ready_d;
  logic [3:0]          wxyz_q, wxyz_d;
  logic [NUM_DIGITS-1:0] digit_en_d;
  logic                frame_done_d;
  logic                bcd_err_d;
  logic                boundary;
  logic                accept;
  logic                zero_run;
  logic [NUM_DIGITS-1:0] visible;

  assign accept       = load_valid && load_ready;
  assign {W, X, Y, Z} = wxyz_q;

  // Next-state, handshake and next registered outputs
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + 1'b1;
    boundary     = 1'b0;
    active_d     = active_q;
    pending_d    = pending_q;
    ready_d      = load_ready;
    wxyz_d       = 4'd0;
    digit_en_d   = '0;
    frame_done_d = 1'b0;
    bcd_err_d    = 1'b0;
    zero_run     = 1'b1;
    visible      = '0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // A pending word wins at the boundary; otherwise a boundary-cycle load goes straight in
    if (boundary) begin
      if (!load_ready) begin
        active_d = pending_q;
        ready_d  = 1'b1;
      end else if (accept) begin
        active_d = load_data;
      end
    end else if (accept) begin
      pending_d = load_data;
      ready_d   = 1'b0;
    end

    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (active_d[4*i +: 4] == 4'd0);
      visible[i] = (active_d[4*i +: 4] <= 4'd9) && !(blank_leading && (i != 0) && zero_run);
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) wxyz_d = active_d[4*i +: 4];
    end

    if (state_d == ST_SHOW) begin
      if (visible[idx_d]) digit_en_d = NUM_DIGITS'(1) << idx_d;
      bcd_err_d    = (cnt_d == '0) && (wxyz_d > 4'd9);
      frame_done_d = (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BLANK;
      idx_q      <= '0;
      cnt_q      <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      load_ready <= 1'b1;
      wxyz_q     <= 4'd0;
      digit_en   <= '0;
      frame_done <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      load_ready <= ready_d;
      wxyz_q     <= wxyz_d;
      digit_en   <= digit_en_d;
      frame_done <= frame_done_d;
      bcd_err    <= bcd_err_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: cycle scoreboard against a frame-position model,
// a table of display words with per-slot expectations, and hand-written corner sequences.
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int P     = 5;
  localparam int FRAME = 20;

  logic        clk;
  logic        reset;
  logic        lv;
  logic        load_ready;
  logic [15:0] ld;
  logic        bl;
  logic        W, X, Y, Z;
  logic [3:0]  digit_en;
  logic        frame_done;
  logic        bcd_err;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (lv),
    .load_ready   (load_ready),
    .load_data    (ld),
    .blank_leading(bl),
    .W            (W),
    .X            (X),
    .Y            (Y),
    .Z            (Z),
    .digit_en     (digit_en),
    .frame_done   (frame_done),
    .bcd_err      (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic        bl;
    logic [15:0] en_slots;  // expected digit_en during SHOW of slot s at [4s+:4]
    logic [3:0]  err_mask;
  } vec_t;

  vec_t        tv[8];
  logic [11:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          k = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_pending = '0;
  logic        m_ready = 1'b1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d actual=%h expected=%h", name, k, act, exp);
    end
  endtask

  // Model of the frame position and load buffering; k counts edges since reset release
  task automatic model_edge(output logic [11:0] e);
    logic [3:0] d;
    logic [3:0] en;
    logic       vis;
    int         slot, w, hi;
    if (reset) begin
      k = 0; m_active = '0; m_pending = '0; m_ready = 1'b1;
    end else begin
      if (k % FRAME == FRAME - 1) begin
        if (!m_ready) begin
          m_active = m_pending;
          m_ready  = 1'b1;
        end else if (lv) begin
          m_active = ld;
        end
      end else if (lv && m_ready) begin
        m_pending = ld;
        m_ready   = 1'b0;
      end
      k++;
    end
    slot = (k / P) % N;
    w    = k % P;
    d    = m_active[4*slot +: 4];
    hi   = -1;
    for (int i = 0; i < N; i++) if (m_active[4*i +: 4] != 4'd0) hi = i;
    vis = (d <= 4'd9) && !(bl && slot != 0 && slot > hi);
    en  = (w != 0 && vis) ? 4'(1 << slot) : 4'd0;
    e   = {m_ready, en, d, (k % FRAME == FRAME - 1), (w == 1 && d > 4'd9)};
  endtask

  task automatic step();
    logic [11:0] e;
    logic [11:0] got;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {load_ready, digit_en, W, X, Y, Z, frame_done, bcd_err};
    check("cycle", 16'(got), 16'(exp_q.pop_front()));
  endtask

  task automatic wait_fd();
    int n = 0;
    while (frame_done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check("frame_done_wait", 16'(frame_done), 16'd1);
  endtask

  task automatic load(input logic [15:0] w);
    int n = 0;
    while (load_ready !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check("ready_wait", 16'(load_ready), 16'd1);
    lv = 1'b1;
    ld = w;
    step();
    lv = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout k=%0d", k);
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{16'h1234, 1'b0, 16'h8421, 4'b0000};
    tv[1] = '{16'h0070, 1'b1, 16'h0021, 4'b0000};
    tv[2] = '{16'h0070, 1'b0, 16'h8421, 4'b0000};
    tv[3] = '{16'h00C1, 1'b0, 16'h8401, 4'b0010};
    tv[4] = '{16'hAAAA, 1'b0, 16'h0000, 4'b1111};
    tv[5] = '{16'h0000, 1'b1, 16'h0001, 4'b0000};
    tv[6] = '{16'h9009, 1'b1, 16'h8421, 4'b0000};
    tv[7] = '{16'h0F05, 1'b1, 16'h0021, 4'b0100};

    reset = 1'b1; lv = 1'b0; ld = '0; bl = 1'b0;
    #1;
    repeat (3) step();
    check("reset_en", 16'(digit_en), 16'd0);
    check("reset_ready", 16'(load_ready), 16'd1);
    reset = 1'b0;

    // Reset release timing: four SHOW cycles of digit 0, one blank, then digit 1
    for (int c = 1; c <= 6; c++) begin
      step();
      check("t1_en", 16'(digit_en), (c <= 4) ? 16'h1 : ((c == 5) ? 16'h0 : 16'h2));
    end

    foreach (tv[v]) begin
      bl = tv[v].bl;
      load(tv[v].word);
      wait_fd();
      for (int j = 0; j < FRAME; j++) begin
        int s, w;
        step();
        s = (k % FRAME) / P;
        w = (k % FRAME) % P;
        check("tbl_wxyz", 16'({W, X, Y, Z}), 16'((tv[v].word >> (4 * s)) & 16'hF));
        if (w != 0) check("tbl_en", 16'(digit_en), (tv[v].en_slots >> (4 * s)) & 16'hF);
        if (w == 1) check("tbl_err", 16'(bcd_err), 16'(tv[v].err_mask[s]));
      end
    end

    // Word held while pending is full waits for the swap at the frame boundary
    bl = 1'b0;
    wait_fd();
    step();
    repeat (3) step();
    lv = 1'b1; ld = 16'hAAAA;
    step();
    ld = 16'h5555;
    begin
      int n = 0;
      while (frame_done !== 1'b1 && n < 40) begin
        check("t4_ready_low", 16'(load_ready), 16'd0);
        step();
        n++;
      end
    end
    check("t4_fd_seen", 16'(frame_done), 16'd1);
    check("t4_ready_at_fd", 16'(load_ready), 16'd0);
    step();
    check("t4_ready_after_swap", 16'(load_ready), 16'd1);
    check("t4_swap_digit", 16'({W, X, Y, Z}), 16'hA);
    step();
    check("t4_5555_accepted", 16'(load_ready), 16'd0);
    lv = 1'b0;
    wait_fd();
    step();
    step();
    check("t4_new_en", 16'(digit_en), 16'h1);
    check("t4_new_digit", 16'({W, X, Y, Z}), 16'h5);

    // Reset mid-SHOW with a word waiting in the pending buffer
    lv = 1'b1; ld = 16'h9876;
    step();
    lv = 1'b0;
    check("t6_pending_full", 16'(load_ready), 16'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_reset_en", 16'(digit_en), 16'd0);
    check("t6_reset_ready", 16'(load_ready), 16'd1);
    check("t6_reset_wxyz", 16'({W, X, Y, Z}), 16'd0);
    wait_fd();
    step();
    step();
    check("t6_pending_lost", 16'({W, X, Y, Z}), 16'd0);
    repeat (FRAME) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
